// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: two-entry skid buffer for instruction/PC pairs.
// in_ready comes from state only, so out_ready never reaches upstream combinationally.
module pipe_skid_stage #(
    parameter int                   INSTR_W   = 32,
    parameter int                   PC_W      = 64,
    parameter logic [INSTR_W-1:0]   NOP_INSTR = 'h13,
    parameter int                   CNT_W     = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_pc,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc,
    output logic [1:0]         count,
    output logic [CNT_W-1:0]   stall_cnt
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
    state_t             state, state_n;
    logic [INSTR_W-1:0] main_instr, skid_instr;
    logic [PC_W-1:0]    main_pc, skid_pc;
    logic               accept, emit, load_in, load_skid, skid_to_main;
    assign in_ready     = state != TWO;
    assign out_valid    = state != EMPTY;
    assign count        = state;
    assign accept       = in_valid && in_ready;
    assign emit         = out_valid && out_ready;
    assign out_instr    = out_valid ? main_instr : NOP_INSTR;
    assign out_pc       = out_valid ? main_pc : '0;
    assign load_in      = accept && (state == EMPTY || emit);
    assign load_skid    = accept && state == ONE && !emit;
    assign skid_to_main = state == TWO && emit;
    always_comb begin
        state_n = state;
        case (state)
            EMPTY:   state_n = accept ? ONE : EMPTY;
            ONE:     state_n = (accept && !emit) ? TWO : ((!accept && emit) ? EMPTY : ONE);
            TWO:     state_n = emit ? ONE : TWO;
            default: state_n = EMPTY;
        endcase
        if (flush) state_n = EMPTY;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= EMPTY;
            stall_cnt <= '0;
        end else begin
            state <= state_n;
            if (out_valid && !out_ready && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
        end
    end
    // Payload registers need no reset; outputs are masked whenever the stage is empty.
    always_ff @(posedge clk) begin
        if (load_in) begin
            main_instr <= in_instr;
            main_pc    <= in_pc;
        end else if (skid_to_main) begin
            main_instr <= skid_instr;
            main_pc    <= skid_pc;
        end
        if (load_skid) begin
            skid_instr <= in_instr;
            skid_pc    <= in_pc;
        end
    end
endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb_pipe_skid_stage: directed vector table plus stall-counter sequence.
module tb_pipe_skid_stage;
    logic        clk = 0;
    logic        reset, in_valid, flush, out_ready;
    logic [31:0] in_instr;
    logic [63:0] in_pc;
    logic        in_ready, out_valid;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic [1:0]  count;
    logic [15:0] stall_cnt;
    logic        in_ready2, out_valid2;
    logic [31:0] out_instr2;
    logic [63:0] out_pc2;
    logic [1:0]  count2;
    logic [1:0]  stall_cnt2;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    pipe_skid_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
        .count(count), .stall_cnt(stall_cnt)
    );

    pipe_skid_stage #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid2),
        .out_ready(out_ready), .out_instr(out_instr2), .out_pc(out_pc2),
        .count(count2), .stall_cnt(stall_cnt2)
    );

    typedef struct {
        logic        rst, iv, fl, ordy;
        logic [31:0] ii;
        logic [63:0] ip;
        logic        ev;
        logic [31:0] ei;
        logic [63:0] ep;
        logic [1:0]  ec;
        logic        er;
    } vec_t;
    vec_t vq[$];

    task automatic add(input logic rst, iv, fl, ordy, input logic [31:0] ii, input logic [63:0] ip,
                       input logic ev, input logic [31:0] ei, input logic [63:0] ep,
                       input logic [1:0] ec, input logic er);
        vec_t v;
        v.rst = rst; v.iv = iv; v.fl = fl; v.ordy = ordy; v.ii = ii; v.ip = ip;
        v.ev = ev; v.ei = ei; v.ep = ep; v.ec = ec; v.er = er;
        vq.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    localparam logic [31:0] NOP = 32'h00000013;

    initial begin
        reset = 0; in_valid = 0; flush = 0; out_ready = 0; in_instr = 0; in_pc = 0;
        // rst iv fl ordy  instr  pc        | ov  instr   pc       cnt ir
        add(1, 0, 0, 0, 32'h0,  64'h0,      0, NOP,    64'h0,    0, 1);
        add(0, 1, 0, 1, 32'hA0, 64'h1000,   1, 32'hA0, 64'h1000, 1, 1);
        add(0, 1, 0, 1, 32'hA1, 64'h1004,   1, 32'hA1, 64'h1004, 1, 1);
        add(0, 1, 0, 1, 32'hA2, 64'h1008,   1, 32'hA2, 64'h1008, 1, 1);
        add(0, 1, 0, 1, 32'hA3, 64'h100C,   1, 32'hA3, 64'h100C, 1, 1);
        add(0, 0, 0, 1, 32'h0,  64'h0,      0, NOP,    64'h0,    0, 1);
        add(0, 1, 0, 0, 32'hB0, 64'h2000,   1, 32'hB0, 64'h2000, 1, 1);
        add(0, 1, 0, 0, 32'hB1, 64'h2004,   1, 32'hB0, 64'h2000, 2, 0);
        add(0, 1, 0, 0, 32'hB2, 64'h2008,   1, 32'hB0, 64'h2000, 2, 0);
        add(0, 1, 0, 1, 32'hB2, 64'h2008,   1, 32'hB1, 64'h2004, 1, 1);
        add(0, 1, 0, 1, 32'hB2, 64'h2008,   1, 32'hB2, 64'h2008, 1, 1);
        add(0, 0, 0, 1, 32'h0,  64'h0,      0, NOP,    64'h0,    0, 1);
        add(0, 1, 0, 0, 32'hC0, 64'h3000,   1, 32'hC0, 64'h3000, 1, 1);
        add(0, 1, 0, 0, 32'hC1, 64'h3004,   1, 32'hC0, 64'h3000, 2, 0);
        add(0, 1, 1, 0, 32'hC2, 64'h3008,   0, NOP,    64'h0,    0, 1);
        add(0, 0, 0, 1, 32'h0,  64'h0,      0, NOP,    64'h0,    0, 1);
        add(0, 1, 0, 0, 32'hD0, 64'h4000,   1, 32'hD0, 64'h4000, 1, 1);
        add(0, 1, 1, 1, 32'hD1, 64'h4004,   0, NOP,    64'h0,    0, 1);
        add(0, 0, 0, 1, 32'h0,  64'h0,      0, NOP,    64'h0,    0, 1);
        add(0, 1, 0, 0, 32'hE0, 64'h5000,   1, 32'hE0, 64'h5000, 1, 1);
        add(0, 0, 0, 0, 32'h0,  64'h0,      1, 32'hE0, 64'h5000, 1, 1);
        add(0, 1, 0, 0, 32'hE1, 64'h5004,   1, 32'hE0, 64'h5000, 2, 0);
        add(1, 1, 1, 1, 32'hE2, 64'h5008,   0, NOP,    64'h0,    0, 1);
        foreach (vq[i]) begin
            reset = vq[i].rst; in_valid = vq[i].iv; flush = vq[i].fl; out_ready = vq[i].ordy;
            in_instr = vq[i].ii; in_pc = vq[i].ip;
            step();
            checks++;
            if ({out_valid, out_instr, out_pc, count, in_ready} !==
                {vq[i].ev, vq[i].ei, vq[i].ep, vq[i].ec, vq[i].er}) begin
                errors++;
                $display("FAIL vec%0d: got v=%0b i=%0h pc=%0h c=%0d r=%0b expected v=%0b i=%0h pc=%0h c=%0d r=%0b",
                         i, out_valid, out_instr, out_pc, count, in_ready,
                         vq[i].ev, vq[i].ei, vq[i].ep, vq[i].ec, vq[i].er);
            end
        end
        check("stall_rst", {48'h0, stall_cnt}, 64'd0);
        check("stall_rst_w2", {62'h0, stall_cnt2}, 64'd0);
        reset = 0; flush = 0; in_valid = 1; in_instr = 32'hF0; in_pc = 64'h6000; out_ready = 0;
        step();
        in_valid = 0;
        check("stall_start", {48'h0, stall_cnt}, 64'd0);
        repeat (5) step();
        check("stall5", {48'h0, stall_cnt}, 64'd5);
        check("stall5_w2", {62'h0, stall_cnt2}, 64'd3);
        check("stall_hold_instr", {32'h0, out_instr}, 64'hF0);
        step();
        check("stall6", {48'h0, stall_cnt}, 64'd6);
        check("stall6_w2_sat", {62'h0, stall_cnt2}, 64'd3);
        out_ready = 1;
        step();
        check("stall_after_emit", {48'h0, stall_cnt}, 64'd6);
        check("empty_after_emit", {63'h0, out_valid}, 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 SHALL have parameter INSTR_W, default 32, instruction payload width.
REQ-002 SHALL have parameter PC_W, default 64, program-counter payload width.
REQ-003 SHALL have parameter NOP_INSTR, default 32'h00000013, value driven on out_instr when no valid entry is held.
REQ-004 SHALL have parameter CNT_W, default 16, stall-counter width.
REQ-005 SHALL have port clk, input, 1, rising-edge clock.
REQ-006 SHALL have port reset, input, 1; reset is synchronous, active-high, sampled on clk rising edge.
REQ-007 SHALL have port in_valid, input, 1, upstream entry valid.
REQ-008 SHALL have port in_ready, output, 1, stage can accept this cycle.
REQ-009 SHALL have port in_instr, input, INSTR_W, upstream instruction.
REQ-010 SHALL have port in_pc, input, PC_W, upstream PC.
REQ-011 SHALL have port flush, input, 1, discard all held and incoming entries.
REQ-012 SHALL have port out_valid, output, 1, downstream entry valid.
REQ-013 SHALL have port out_ready, input, 1, downstream accepts this cycle.
REQ-014 SHALL have port out_instr, output, INSTR_W, head-entry instruction.
REQ-015 SHALL have port out_pc, output, PC_W, head-entry PC.
REQ-016 SHALL have port count, output, 2, entries held (0..2).
REQ-017 SHALL have port stall_cnt, output, CNT_W, saturating count of cycles with out_valid=1 and out_ready=0.

Function
REQ-018 SHALL hold up to two entries: main register (head) and skid register; state EMPTY (0), ONE (1), TWO (2); count equals state encoding.
REQ-019 SHALL drive in_ready from registers only: in_ready=1 in EMPTY and ONE, 0 in TWO; no combinational path from out_ready to in_ready.
REQ-020 SHALL define accept = in_valid & in_ready, emit = out_valid & out_ready, both evaluated in the same cycle.
REQ-021 SHALL have out_valid=1 exactly in ONE and TWO; out_instr/out_pc show main register.
REQ-022 SHALL, when out_valid=0, drive out_instr=NOP_INSTR and out_pc=0.
REQ-023 SHALL have latency 1: entry accepted in cycle N in EMPTY appears on outputs in cycle N+1.
REQ-024 SHALL transition EMPTY: accept -> ONE (load main); else stay.
REQ-025 SHALL transition ONE: accept&emit -> ONE (main <= input); accept&!emit -> TWO (skid <= input); !accept&emit -> EMPTY; else stay.
REQ-026 SHALL transition TWO: emit -> ONE (main <= skid); else stay; inputs ignored since in_ready=0.
REQ-027 SHALL preserve strict FIFO order; no entry duplicated or lost absent flush/reset.
REQ-028 SHALL hold outputs stable while out_valid=1 and out_ready=0.
REQ-029 SHALL, on flush=1, go to EMPTY next cycle, discarding main, skid and any entry offered that cycle; flush overrides accept and emit.
REQ-030 SHALL keep in_ready per REQ-019 during the flush cycle; upstream sees accept but entry is dropped.
REQ-031 SHALL increment stall_cnt by 1 each cycle out_valid=1 and out_ready=0, saturating at all-ones; flush does not clear it.

Reset
REQ-032 SHALL, on reset=1 at a clk edge, set state EMPTY, count=0, out_valid=0, out_instr=NOP_INSTR, out_pc=0, in_ready=1, stall_cnt=0.
REQ-033 SHALL give reset priority over flush and all handshakes, including mid-operation in state TWO.

Verification
REQ-034 SHALL test pass-through: out_ready=1, feed instr 0xA0..0xA3 with pc 0x1000..0x100C back-to-back -> same sequence out one cycle later, count stays 1, in_ready stays 1.
REQ-035 SHALL test skid fill: out_ready=0, offer 0xB0 then 0xB1 then 0xB2 -> count 1,2; in_ready=0 after second; 0xB2 held upstream; release out_ready -> 0xB0,0xB1,0xB2 in order.
REQ-036 SHALL test flush in TWO with in_valid=1 -> next cycle out_valid=0, out_instr=0x00000013, out_pc=0, count=0; offered entry never appears.
REQ-037 SHALL test stall counter: out_valid=1, out_ready=0 for 5 cycles -> stall_cnt=5; with CNT_W=2 and 6 cycles -> stall_cnt=3.
REQ-038 SHALL test reset mid-operation in TWO with flush=1 -> all outputs at REQ-032 values next cycle.
REQ-039 SHALL test simultaneous accept and emit in ONE: main replaced by new entry, count remains 1, no bubble.
